audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_vol_mix.sv | 56 +++++
 rtl/audio_i2s_tx.sv | 114 +++++++++++
 tb/tb_audio_i2s_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared encodings and helpers for the I2S audio transmitter.
package audio_pkg;
  localparam int FMT_LJ  = 0;
  localparam int FMT_I2S = 1;

  localparam logic [1:0] VOL_MUTE    = 2'd0;
  localparam logic [1:0] VOL_QUARTER = 2'd1;
  localparam logic [1:0] VOL_HALF    = 2'd2;
  localparam logic [1:0] VOL_FULL    = 2'd3;

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

  // Saturation decision for a sum carried one bit wider than its target:
  // the two top bits disagree only when the narrow result would wrap.
  function automatic sat_e sat_kind(input logic [1:0] top);
    case (top)
      2'b01:   return SAT_POS;
      2'b10:   return SAT_NEG;
      default: return SAT_NONE;
    endcase
  endfunction
endpackage

// File: rtl/audio_vol_mix.sv
// Combinational sample conditioning: sign-extend, volume, optional mono mix
// with saturation, then a fixed arithmetic attenuation.
module audio_vol_mix
  import audio_pkg::*;
#(
  parameter int IN_WIDTH = 15,
  parameter int WIDTH    = 16,
  parameter int MIX      = 1,
  parameter int SHIFT    = 3
) (
  input  logic [IN_WIDTH-1:0] audio_l,
  input  logic [IN_WIDTH-1:0] audio_r,
  input  logic [1:0]          volume,
  output logic [WIDTH-1:0]    word_l,
  output logic [WIDTH-1:0]    word_r
);
  logic signed [WIDTH-1:0] ext_l, ext_r, vol_l, vol_r;

  function automatic logic signed [WIDTH-1:0] apply_vol(input logic signed [WIDTH-1:0] v,
                                                       input logic [1:0]              vol);
    case (vol)
      VOL_MUTE:    return '0;
      VOL_QUARTER: return v >>> 2;
      VOL_HALF:    return v >>> 1;
      VOL_FULL:    return v;
      default:     return v;
    endcase
  endfunction

  always_comb begin
    ext_l = {{(WIDTH-IN_WIDTH){audio_l[IN_WIDTH-1]}}, audio_l};
    ext_r = {{(WIDTH-IN_WIDTH){audio_r[IN_WIDTH-1]}}, audio_r};
    vol_l = apply_vol(ext_l, volume);
    vol_r = apply_vol(ext_r, volume);
  end

  if (MIX != 0) begin : g_mix
    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] sat;
    always_comb begin
      sum = {vol_l[WIDTH-1], vol_l} + {vol_r[WIDTH-1], vol_r};
      case (sat_kind(sum[WIDTH -: 2]))
        SAT_POS: sat = {1'b0, {(WIDTH-1){1'b1}}};
        SAT_NEG: sat = {1'b1, {(WIDTH-1){1'b0}}};
        default: sat = sum[WIDTH-1:0];
      endcase
      word_l = sat >>> SHIFT;
      word_r = sat >>> SHIFT;
    end
  end else begin : g_stereo
    always_comb begin
      word_l = vol_l >>> SHIFT;
      word_r = vol_r >>> SHIFT;
    end
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified serializer: divides clk into a bit clock, shifts a
// latched left/right word pair out MSB-first, and re-latches once per frame.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 28542800,
  parameter int SAMPLE_HZ = 24000,
  parameter int IN_WIDTH  = 15,
  parameter int WIDTH     = 16,
  parameter int MIX       = 1,
  parameter int FORMAT    = 0,
  parameter int SHIFT     = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] audio_l,
  input  logic [IN_WIDTH-1:0] audio_r,
  input  logic [1:0]          volume,
  output logic                hp_bck,
  output logic                hp_ws,
  output logic                hp_din,
  output logic                sample_strobe
);
  localparam int HALF  = CLK_HZ / (SAMPLE_HZ * 4 * WIDTH);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SLOTS = 2 * WIDTH;
  localparam int BIT_W = $clog2(SLOTS);

  if (WIDTH < IN_WIDTH + 1) begin : g_chk_width
    $error("audio_i2s_tx: WIDTH must be at least IN_WIDTH+1");
  end
  if (HALF < 1) begin : g_chk_half
    $error("audio_i2s_tx: clock too slow for requested sample rate and width");
  end

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] word_l_q, word_l_d, word_r_q, word_r_d;
  logic [WIDTH-1:0] proc_l, proc_r, slot_word, slot_bits;
  logic             hp_bck_q, hp_bck_d, hp_ws_q, hp_ws_d, hp_din_q, hp_din_d;
  logic             strobe_q, strobe_d, tick;
  int               slot_j;

  audio_vol_mix #(
    .IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .MIX(MIX), .SHIFT(SHIFT)
  ) u_vol_mix (
    .audio_l(audio_l), .audio_r(audio_r), .volume(volume),
    .word_l(proc_l),   .word_r(proc_r)
  );

  always_comb begin
    div_cnt_d = div_cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    word_l_d  = word_l_q;
    word_r_d  = word_r_q;
    hp_bck_d  = hp_bck_q;
    hp_ws_d   = hp_ws_q;
    hp_din_d  = hp_din_q;
    strobe_d  = 1'b0;
    slot_j    = 0;
    slot_word = '0;
    slot_bits = '0;
    tick      = (div_cnt_q == CNT_W'(HALF - 1));
    if (tick) begin
      div_cnt_d = '0;
      hp_bck_d  = ~hp_bck_q;
    end
    if (tick && hp_bck_q) begin
      if (bit_cnt_q == BIT_W'(SLOTS - 1)) begin
        bit_cnt_d = '0;
        word_l_d  = proc_l;
        word_r_d  = proc_r;
        strobe_d  = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
      slot_j = int'(bit_cnt_d) - FORMAT;
      if (slot_j < 0) slot_j = slot_j + SLOTS;
      slot_word = (slot_j < WIDTH) ? word_l_d : word_r_d;
      // In I2S mode slot 0 still belongs to the outgoing frame's right LSB.
      if (FORMAT == FMT_I2S && bit_cnt_d == '0) slot_word = word_r_q;
      slot_bits = slot_word << (slot_j % WIDTH);
      hp_din_d  = slot_bits[WIDTH-1];
      hp_ws_d   = int'(bit_cnt_d) >= WIDTH;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      word_l_q  <= '0;
      word_r_q  <= '0;
      hp_bck_q  <= 1'b0;
      hp_ws_q   <= 1'b0;
      hp_din_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      word_l_q  <= word_l_d;
      word_r_q  <= word_r_d;
      hp_bck_q  <= hp_bck_d;
      hp_ws_q   <= hp_ws_d;
      hp_din_q  <= hp_din_d;
      strobe_q  <= strobe_d;
    end
  end

  assign hp_bck        = hp_bck_q;
  assign hp_ws         = hp_ws_q;
  assign hp_din        = hp_din_q;
  assign sample_strobe = strobe_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: four parameter variants share one stimulus; the
// serial stream is reassembled into words and compared with an arithmetic model.
module tb_audio_i2s_tx;
  localparam int CLK_HZ    = 6144000;
  localparam int SAMPLE_HZ = 48000;
  localparam int IN_W      = 15;
  localparam int W         = 16;
  localparam int FRAME_CLK = 128;
  localparam int HALF_CLK  = 2;
  localparam int N         = 4;
  localparam logic [N-1:0] MIX_P = 4'b1100;
  localparam logic [N-1:0] FMT_P = 4'b1010;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [IN_W-1:0] audio_l = '0;
  logic [IN_W-1:0] audio_r = '0;
  logic [1:0]      volume = 2'd3;
  logic            bck [N];
  logic            ws  [N];
  logic            din [N];
  logic            stb [N];
  int              n_assert = 0;
  int              n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    audio_i2s_tx #(
      .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .IN_WIDTH(IN_W), .WIDTH(W),
      .MIX(int'(MIX_P[g])), .FORMAT(int'(FMT_P[g])), .SHIFT((g == 3) ? 3 : 0)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .audio_l(audio_l), .audio_r(audio_r),
      .volume(volume), .hp_bck(bck[g]), .hp_ws(ws[g]), .hp_din(din[g]),
      .sample_strobe(stb[g])
    );
  end

  function automatic int shift_of(input int i);
    return (i == 3) ? 3 : 0;
  endfunction

  // floor(a / 2**n), i.e. what an arithmetic right shift must produce
  function automatic int fdiv(input int a, input int n);
    int d;
    d = 1 << n;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int sext(input logic [IN_W-1:0] v);
    int r;
    r = int'(v);
    if (v[IN_W-1]) r = r - (1 << IN_W);
    return r;
  endfunction

  function automatic int gain(input int v, input logic [1:0] vol);
    case (vol)
      2'd0:    return 0;
      2'd1:    return fdiv(v, 2);
      2'd2:    return fdiv(v, 1);
      default: return v;
    endcase
  endfunction

  task automatic model(input int i, input logic [IN_W-1:0] l, input logic [IN_W-1:0] r,
                       input logic [1:0] vol, output logic [W-1:0] el, output logic [W-1:0] er);
    int a, b, s;
    a = gain(sext(l), vol);
    b = gain(sext(r), vol);
    if (MIX_P[i]) begin
      s = a + b;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      s = fdiv(s, shift_of(i));
      el = 16'(s);
      er = 16'(s);
    end else begin
      el = 16'(fdiv(a, shift_of(i)));
      er = 16'(fdiv(b, shift_of(i)));
    end
  endtask

  function automatic logic [15:0] pack_outs();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = {bck[i], ws[i], din[i], stb[i]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input int limit, output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (stb[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_strobe_timeout"}, 32'd0, 32'd1);
  endtask

  // Cycles from release until the first strobe; also records the first bck rise.
  task automatic count_from_release(output int first_bck, output int first_stb);
    first_bck = -1;
    first_stb = -1;
    for (int c = 1; c <= 2 * FRAME_CLK; c++) begin
      @(negedge clk);
      if (first_bck < 0 && bck[0]) first_bck = c;
      if (stb[0]) begin
        first_stb = c;
        break;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [IN_W-1:0] l,
                           input logic [IN_W-1:0] r, input logic [1:0] vol);
    logic [W-1:0]  el [N];
    logic [W-1:0]  er [N];
    logic [32:0]   slot_bits [N];
    logic [31:0]   ws_bits;
    logic [W-1:0]  ol, orr;
    logic          prev;
    int            cyc;
    bit            ok;
    @(negedge clk);
    audio_l = l;
    audio_r = r;
    volume  = vol;
    for (int i = 0; i < N; i++) model(i, l, r, vol, el[i], er[i]);
    wait_strobe(tag, 4 * FRAME_CLK, cyc, ok);
    if (!ok) return;
    // disturb inputs while the frame is in flight
    audio_l = IN_W'($urandom);
    audio_r = IN_W'($urandom);
    volume  = 2'($urandom);
    prev = bck[0];
    ws_bits = '0;
    for (int s = 0; s < 33; s++) begin
      ok = 1'b0;
      for (int c = 0; c < 4 * HALF_CLK; c++) begin
        @(negedge clk);
        if (bck[0] && !prev) ok = 1'b1;
        prev = bck[0];
        if (ok) break;
      end
      if (!ok) begin
        check({tag, "_bck_timeout"}, 32'd0, 32'd1);
        return;
      end
      for (int i = 0; i < N; i++) slot_bits[i][s] = din[i];
      if (s < 32) ws_bits[s] = ws[0];
    end
    for (int i = 0; i < N; i++) begin
      for (int b = 0; b < W; b++) begin
        ol[W-1-b]  = slot_bits[i][b + int'(FMT_P[i])];
        orr[W-1-b] = slot_bits[i][W + b + int'(FMT_P[i])];
      end
      check($sformatf("%s_left%0d", tag, i), {16'h0, ol}, {16'h0, el[i]});
      check($sformatf("%s_right%0d", tag, i), {16'h0, orr}, {16'h0, er[i]});
    end
    check({tag, "_ws"}, ws_bits, 32'hFFFF_0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fb, fs, cyc;
    bit  ok;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {16'h0, pack_outs()}, 32'h0);
    reset_n = 1'b1;
    count_from_release(fb, fs);
    check("first_bck_rise", fb, HALF_CLK);
    check("first_strobe", fs, FRAME_CLK);
    @(negedge clk);
    check("strobe_width", {31'h0, stb[0]}, 32'h0);
    wait_strobe("period", 4 * FRAME_CLK, cyc, ok);
    check("strobe_period", cyc + 1, FRAME_CLK);

    run_frame("basic",    15'h1234, 15'h7ABC, 2'd3);
    run_frame("sat_pos",  15'h3FFF, 15'h3FFF, 2'd3);
    run_frame("sat_neg",  15'h4000, 15'h4000, 2'd3);
    run_frame("mute",     IN_W'($urandom), IN_W'($urandom), 2'd0);
    run_frame("quarter",  15'h0100, IN_W'($urandom), 2'd1);
    run_frame("half",     IN_W'($urandom), IN_W'($urandom), 2'd2);
    for (int k = 0; k < 8; k++)
      run_frame($sformatf("rand%0d", k), IN_W'($urandom), IN_W'($urandom), 2'($urandom));

    wait_strobe("pre_rst", 4 * FRAME_CLK, cyc, ok);
    repeat (37) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {16'h0, pack_outs()}, 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_held", {16'h0, pack_outs()}, 32'h0);
    reset_n = 1'b1;
    count_from_release(fb, fs);
    check("midrst_first_strobe", fs, FRAME_CLK);
    run_frame("after_rst", IN_W'($urandom), IN_W'($urandom), 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
